pe27_mac: RTL and testbench
===========================

// Module: pe27_mac
// PURPOSE
//   Sequential 27-term multiply-accumulate processing element: sum(w[i]*x[i]), i=0..26.
//   Sized for one 3x3x3 convolution window (3x3 kernel, 3 input channels) of the
//   YOLO conv datapath. One product is accumulated per clock.
//   Controlled by a start/busy/done handshake from the conv-layer scheduler.
// PARAMETERS
//   N_TERMS  27  number of products accumulated per operation
//   DATA_W   8   width of each weight/input element
//   ACC_W    24  accumulator/result width (max 27*255*255 = 1,755,675 fits, no overflow)
// PORTS
//   clk           in   1                    system clock, rising-edge active
//   rst_n         in   1                    asynchronous active-low reset
//   start         in   1                    single-cycle request to begin an operation
//   weights_flat  in   N_TERMS*DATA_W (216) weight i at bits [8i+7:8i]
//   inputs_flat   in   N_TERMS*DATA_W (216) input  i at bits [8i+7:8i]
//   mac_out       out  ACC_W (24)           result of last completed operation
//   busy          out  1                    high while an operation is in progress
//   done          out  1                    one-cycle completion pulse
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset values: mac_out=0, busy=0, done=0, FSM=IDLE, counter=0, accumulator=0.
// - FSM states: IDLE, RUN.
// - IDLE: start=1 sampled on edge E0 -> latch both 216-bit operand buses into internal registers.
//   The same edge clears the accumulator, sets idx=0 and busy=1, and moves to RUN.
// - Operands are sampled only at E0. Bus changes after E0 do not affect the result.
// - RUN, edges E1..E27: acc <= acc + zext(w[idx])*zext(x[idx]), then idx <= idx+1.
//   Products are 16-bit, zero-extended to ACC_W.
// - E27 (idx==26): mac_out <= final sum, done <= 1, busy <= 0, FSM -> IDLE.
//   done therefore rises 27 clocks after the start-capture edge.
// - done is high for exactly one cycle. mac_out holds its value until the next completion.
//   mac_out is not cleared by start.
// - start while busy=1 is ignored; it is neither queued nor restarts the operation.
// - start may be sampled on the edge after done rises (back-to-back operations).
//   Minimum issue interval is 28 cycles.
// - busy and done are never high together.
// - rst_n asserted mid-operation: immediate abort to reset values. No done pulse is issued.
// - Accumulation wraps modulo 2^ACC_W. This cannot occur with 8-bit operands and 27 terms.
// CONFIGURATION
//   PE27_SIGNED_EN defined: w[i] and x[i] are two's-complement signed 8-bit values.
//     Products are signed 16-bit, sign-extended to 24 bits.
//     mac_out is a 24-bit two's-complement sum; range fits without overflow.
//   PE27_SIGNED_EN undefined (default): all operands are unsigned, zero-extended as above.
//   Timing and handshake are identical in both builds.
// TESTING
//   1. All 27 w=1, x=1; pulse start -> done after 27 clk, mac_out=27 (bits[23:8]=0), busy low.
//   2. w[0..8]=2, x[0..8]=3, others 0 -> mac_out=54.
//   3. All 27 w=2, x=2 -> mac_out=108.
//      Run cases 1-3 back-to-back; mac_out holds between runs.
//   4. All w=x=255 (unsigned build) -> mac_out=1,755,675 (0x1ACA1B).
//      Signed build: all w=0xFF, x=0x01 -> mac_out=0xFFFFE5 (-27).
//   5. Pulse start again mid-run and change operand buses -> ignored.
//      Result matches operands latched at the first start; done exactly once.
//   6. Assert rst_n low at idx~10 -> busy=0, done=0, mac_out=0 immediately.
//      Release and run case 1 -> 27.

Source files
------------

// File: rtl/pe27_mac.sv
// pe27_mac: sequential 27-term multiply-accumulate element with a start/busy/done handshake.
// Define PE27_SIGNED_EN for two's-complement operands; the default build treats them as unsigned.
//
// state  | meaning
// S_IDLE | waiting for start; mac_out holds the last result
// S_RUN  | one product accumulated per clock, idx 0..N_TERMS-1
module pe27_mac #(
    parameter int N_TERMS = 27,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_TERMS*DATA_W-1:0]   weights_flat,
    input  logic [N_TERMS*DATA_W-1:0]   inputs_flat,
    output logic [ACC_W-1:0]            mac_out,
    output logic                        busy,
    output logic                        done
);

    localparam int                IDX_W    = $clog2(N_TERMS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_TERMS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [N_TERMS*DATA_W-1:0]   r_w_reg;
    logic [N_TERMS*DATA_W-1:0]   r_x_reg;
    logic [IDX_W-1:0]            r_idx;
    logic [ACC_W-1:0]            r_acc;
    logic [ACC_W-1:0]            r_mac_out;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_capture;
    logic                        w_last;
    logic [DATA_W-1:0]           w_w_elem;
    logic [DATA_W-1:0]           w_x_elem;
    logic [ACC_W-1:0]            w_prod_ext;
    logic [ACC_W-1:0]            w_acc_nxt;

    assign w_w_elem = r_w_reg[r_idx*DATA_W +: DATA_W];
    assign w_x_elem = r_x_reg[r_idx*DATA_W +: DATA_W];

`ifdef PE27_SIGNED_EN
    logic signed [DATA_W-1:0]    w_w_s;
    logic signed [DATA_W-1:0]    w_x_s;
    logic signed [2*DATA_W-1:0]  w_prod;
    assign w_w_s      = w_w_elem;
    assign w_x_s      = w_x_elem;
    assign w_prod     = w_w_s * w_x_s;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
`else
    logic [2*DATA_W-1:0]         w_prod;
    assign w_prod     = w_w_elem * w_x_elem;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
`endif

    assign w_acc_nxt = r_acc + w_prod_ext;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here: requests while busy are dropped
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_w_reg   <= '0;
            r_x_reg   <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_mac_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_capture) begin
                r_w_reg <= weights_flat;
                r_x_reg <= inputs_flat;
                r_acc   <= '0;
                r_idx   <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_idx <= r_idx + IDX_ONE;
                if (w_last) begin
                    r_mac_out <= w_acc_nxt;
                    r_busy    <= 1'b0;
                    r_idx     <= '0;
                end
            end
        end
    end

    assign mac_out = r_mac_out;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_pe27_mac.sv
// Directed table-driven bench for pe27_mac: back-to-back vectors, ignored restart, mid-run reset.
module tb_pe27_mac;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [215:0] weights_flat;
    logic [215:0] inputs_flat;
    logic [23:0]  mac_out;
    logic         busy;
    logic         done;

    int n_tests;
    int n_fail;
    int n_overlap;

    pe27_mac dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .weights_flat (weights_flat),
        .inputs_flat  (inputs_flat),
        .mac_out      (mac_out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) n_overlap++;

    typedef struct {
        logic [215:0] w;
        logic [215:0] x;
        logic [23:0]  exp;
        string        name;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [215:0] bus(input logic [7:0] v, input int n);
        logic [215:0] b;
        b = '0;
        for (int i = 0; i < 27; i++)
            if (i < n) b[8*i +: 8] = v;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Call at a negedge: drives the request so it is sampled on the next rising edge (E0).
    task automatic start_op(input logic [215:0] w, input logic [215:0] x);
        weights_flat = w;
        inputs_flat  = x;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Returns the number of negedges after E0 until done is seen (40 = timed out).
    task automatic wait_done(output int lat, output int pulses);
        lat    = 0;
        pulses = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done) pulses = 1;
    endtask

    int lat;
    int pulses;
    int extra;

    initial begin
        n_tests = 0; n_fail = 0; n_overlap = 0;
        rst_n = 1'b0; start = 1'b0; weights_flat = '0; inputs_flat = '0;

        vecs[0] = '{bus(8'd1, 27), bus(8'd1, 27), 24'd27,  "all_ones"};
        vecs[1] = '{bus(8'd2, 9),  bus(8'd3, 9),  24'd54,  "nine_2x3"};
        vecs[2] = '{bus(8'd2, 27), bus(8'd2, 27), 24'd108, "all_twos"};
`ifdef PE27_SIGNED_EN
        vecs[3] = '{bus(8'hFF, 27), bus(8'h01, 27), 24'hFFFFE5, "minus27"};
`else
        vecs[3] = '{bus(8'hFF, 27), bus(8'hFF, 27), 24'h1ACA1B, "all_max"};
`endif

        repeat (3) @(negedge clk);
        chk("reset_mac_out", 32'(mac_out), 32'd0);
        chk("reset_busy",    32'(busy),    32'd0);
        chk("reset_done",    32'(done),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each new start is driven on the negedge where done is seen.
        start_op(vecs[0].w, vecs[0].x);
        for (int i = 0; i < 4; i++) begin
            chk({vecs[i].name, "_busy_run"}, 32'(busy), 32'd1);
            wait_done(lat, pulses);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'd27);
            chk({vecs[i].name, "_result"}, 32'(mac_out), 32'(vecs[i].exp));
            chk({vecs[i].name, "_busy_at_done"}, 32'(busy), 32'd0);
            if (i < 3) start_op(vecs[i+1].w, vecs[i+1].x);
            else @(negedge clk);
            chk({vecs[i].name, "_done_one_cycle"}, 32'(done), 32'd0);
            chk({vecs[i].name, "_mac_out_hold"}, 32'(mac_out), 32'(vecs[i].exp));
        end

        // Restart attempt with different operands mid-run must be ignored.
        repeat (2) @(negedge clk);
        start_op(bus(8'd3, 27), bus(8'd1, 27));
        repeat (4) @(negedge clk);
        weights_flat = bus(8'd7, 27);
        inputs_flat  = bus(8'd5, 27);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        lat = 7;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("restart_latency", 32'(lat), 32'd27);
        chk("restart_result", 32'(mac_out), 32'd81);
        extra = 0;
        repeat (35) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("restart_single_done", 32'(extra), 32'd0);
        chk("restart_busy_after", 32'(busy), 32'd0);

        // Reset around idx 10 aborts immediately; no done pulse follows.
        start_op(bus(8'd1, 27), bus(8'd1, 27));
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy",    32'(busy),    32'd0);
        chk("abort_done",    32'(done),    32'd0);
        chk("abort_mac_out", 32'(mac_out), 32'd0);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort_no_done", 32'(extra), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(vecs[0].w, vecs[0].x);
        wait_done(lat, pulses);
        chk("after_abort_latency", 32'(lat), 32'd27);
        chk("after_abort_result", 32'(mac_out), 32'd27);
        @(negedge clk);

        chk("busy_done_never_both", 32'(n_overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
